// File: rtl/bytecode_byte_fetch.sv
// bytecode_byte_fetch
//
// Purpose:
//   Supplies one bytecode byte per single-cycle fetch request and owns the
//   JVM program counter. A one-halfword line buffer sits in front of the
//   16-bit, big-endian bytecode memory, so the second byte of a halfword is
//   normally served without a memory access. Delivered bytes are also
//   shifted into a 32-bit operand accumulator for the decode state machine.
//
// Ports:
//   clk, rst_n      - single rising-edge clock, asynchronous active-low reset
//   fetch           - request next byte (sampled only while busy = 0)
//   pc_load         - load pc_load_value into the PC (branch/invoke target)
//   pc_load_value   - target byte address
//   operand_clr     - clear the operand accumulator
//   mem_req         - bytecode memory read request, held until mem_ack
//   mem_addr        - halfword address of the request
//   mem_ack         - read data valid this cycle
//   mem_rdata       - halfword read data, even byte in [15:8]
//   byte_valid      - one-cycle pulse, byte_out is valid
//   byte_out        - delivered bytecode byte
//   operand         - shift accumulator of delivered bytes
//   pc              - byte address of the next byte to deliver
//   param_even      - high when pc is even
//   busy            - high whenever a request is in progress
module bytecode_byte_fetch #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_value,
  input  logic              operand_clr,
  output logic              mem_req,
  output logic [ADDR_W-2:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              byte_valid,
  output logic [7:0]        byte_out,
  output logic [31:0]       operand,
  output logic [ADDR_W-1:0] pc,
  output logic              param_even,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DELIVER = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [15:0]       buf_data;
  logic [ADDR_W-2:0] buf_addr;
  logic              buf_valid;

  logic [ADDR_W-2:0] pc_hw;
  logic              buf_hit;
  logic [15:0]       src_half;

  logic              mem_req_d;
  logic [ADDR_W-2:0] mem_addr_d;
  logic              byte_valid_d;
  logic [7:0]        byte_out_d;

  assign pc_hw      = pc[ADDR_W-1:1];
  assign buf_hit    = buf_valid && (buf_addr == pc_hw);
  assign param_even = ~pc[0];
  assign busy       = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A fetch that coincides with a PC load is dropped,
  // because it would refer to the PC that is being replaced. A load that
  // lands in the same cycle as the ack needs no drain: the request is
  // already complete, so its data is simply discarded.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (fetch && !pc_load) begin
          next_state = buf_hit ? DELIVER : REQ;
        end
      end
      REQ: begin
        if (pc_load) begin
          next_state = mem_ack ? IDLE : DRAIN;
        end else if (mem_ack) begin
          next_state = DELIVER;
        end
      end
      DELIVER: next_state = IDLE;
      DRAIN: begin
        if (mem_ack) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode. All memory-side and byte outputs are registered, so this
  // computes their values for the coming state. The request address is
  // captured only when a request starts and is then held, even across a
  // PC load, so the memory sees a stable request until it acknowledges.
  always_comb begin
    src_half     = (state == REQ) ? mem_rdata : buf_data;
    mem_req_d    = (next_state == REQ) || (next_state == DRAIN);
    mem_addr_d   = ((state == IDLE) && (next_state == REQ)) ? pc_hw : mem_addr;
    byte_valid_d = (next_state == DELIVER);
    byte_out_d   = byte_out;
    if (next_state == DELIVER) begin
      byte_out_d = pc[0] ? src_half[7:0] : src_half[15:8];
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      byte_valid <= 1'b0;
      byte_out   <= 8'h00;
    end else begin
      mem_req    <= mem_req_d;
      mem_addr   <= mem_addr_d;
      byte_valid <= byte_valid_d;
      byte_out   <= byte_out_d;
    end
  end

  // PC and line buffer. Any PC load invalidates the buffer; a load during
  // DELIVER overrides the post-delivery increment. The buffer is filled
  // only by an ack that is not cancelled by a simultaneous load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= '0;
      buf_data  <= 16'h0000;
      buf_addr  <= '0;
      buf_valid <= 1'b0;
    end else begin
      if (pc_load) begin
        pc        <= pc_load_value;
        buf_valid <= 1'b0;
      end else begin
        if (state == DELIVER) begin
          pc <= pc + ADDR_W'(1);
        end
        if ((state == REQ) && mem_ack) begin
          buf_data  <= mem_rdata;
          buf_addr  <= mem_addr;
          buf_valid <= 1'b1;
        end
      end
    end
  end

  // Operand accumulator. A clear together with a delivered byte restarts
  // the accumulation with that byte rather than losing it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand <= 32'h0;
    end else if (byte_valid) begin
      operand <= operand_clr ? {24'h0, byte_out} : {operand[23:0], byte_out};
    end else if (operand_clr) begin
      operand <= 32'h0;
    end
  end

endmodule

// File: tb/tb_bytecode_byte_fetch.sv
// tb_bytecode_byte_fetch
//
// Purpose:
//   Self-checking bench for bytecode_byte_fetch. A transaction-level model
//   tracks what the fetcher must be doing and which byte each delivery must
//   carry (read straight from the bench memory image by byte address).
//   Directed scenarios pin key values by hand; a randomized phase then
//   exercises fetches, loads, clears and variable memory latency.
//
// Ports: none (top-level bench).
module tb_bytecode_byte_fetch;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              fetch = 1'b0;
  logic              pc_load = 1'b0;
  logic [ADDR_W-1:0] pc_load_value = '0;
  logic              operand_clr = 1'b0;
  logic              mem_req;
  logic [ADDR_W-2:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [15:0]       mem_rdata = 16'h0;
  logic              byte_valid;
  logic [7:0]        byte_out;
  logic [31:0]       operand;
  logic [ADDR_W-1:0] pc;
  logic              param_even;
  logic              busy;

  int check_count = 0;
  int error_count = 0;

  logic [15:0] mem [0:32767];

  int random_mode = 0;
  int fixed_delay = 0;
  int ack_wait = 0;

  typedef enum {PH_IDLE, PH_WAIT, PH_GIVE, PH_DISCARD} phase_t;
  phase_t      m_phase = PH_IDLE;
  logic [15:0] m_pc = 16'h0;
  logic        m_bvalid = 1'b0;
  logic [14:0] m_btag = 15'h0;
  logic [14:0] m_req_addr = 15'h0;
  logic [31:0] m_operand = 32'h0;
  logic [7:0]  m_give_byte = 8'h0;

  bytecode_byte_fetch #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch        (fetch),
    .pc_load      (pc_load),
    .pc_load_value(pc_load_value),
    .operand_clr  (operand_clr),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .byte_valid   (byte_valid),
    .byte_out     (byte_out),
    .operand      (operand),
    .pc           (pc),
    .param_even   (param_even),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // One comparison: counts it, and reports a FAIL line on a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of upstream inputs, then return them to idle.
  task automatic applyStimulus(input logic f, input logic pl,
                               input logic [15:0] plv, input logic clr);
    fetch         = f;
    pc_load       = pl;
    pc_load_value = plv;
    operand_clr   = clr;
    @(negedge clk);
    fetch       = 1'b0;
    pc_load     = 1'b0;
    operand_clr = 1'b0;
  endtask

  // Byte the specification says lives at byte address a (big-endian).
  function automatic logic [7:0] byte_at(input logic [15:0] a);
    logic [15:0] w;
    w = mem[a[15:1]];
    return a[0] ? w[7:0] : w[15:8];
  endfunction

  // Wait (bounded) for a delivery and return the byte shown with it.
  task automatic wait_byte(input string name, output logic [7:0] b);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (byte_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput({name, "_arrived"}, {31'h0, got}, 32'h1);
    b = byte_out;
  endtask

  // Full request: fetch, wait for the byte, then one cycle back to idle,
  // optionally clearing the operand in the delivery cycle.
  task automatic fetch_one(input string name, input logic clr_with,
                           output logic [7:0] b);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    wait_byte(name, b);
    applyStimulus(1'b0, 1'b0, 16'h0, clr_with);
  endtask

  // Memory responder: acks a held request after a fixed or random number
  // of cycles, returning the image word at the requested address. Data is
  // junk whenever it is not being acknowledged.
  always @(negedge clk) begin
    if (!rst_n || !mem_req) begin
      mem_ack   = 1'b0;
      mem_rdata = 16'($urandom);
      ack_wait  = (random_mode != 0) ? int'($urandom_range(0, 3)) : fixed_delay;
    end else if (ack_wait == 0) begin
      mem_ack   = 1'b1;
      mem_rdata = mem[mem_addr];
      ack_wait  = (random_mode != 0) ? int'($urandom_range(0, 3)) : fixed_delay;
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 16'($urandom);
      ack_wait--;
    end
  end

  // Reference model. It tracks the fetcher as a sequence of transactions:
  // waiting for a request, waiting on memory, handing over a byte, or
  // discarding a request abandoned by a PC load. The delivered byte is
  // taken from the memory image at the PC, not from any captured data.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase     = PH_IDLE;
      m_pc        = 16'h0;
      m_bvalid    = 1'b0;
      m_btag      = 15'h0;
      m_req_addr  = 15'h0;
      m_operand   = 32'h0;
      m_give_byte = 8'h0;
    end else begin
      if (m_phase == PH_GIVE) begin
        m_operand = operand_clr ? {24'h0, m_give_byte}
                                : ((m_operand << 8) | {24'h0, m_give_byte});
      end else if (operand_clr) begin
        m_operand = 32'h0;
      end
      case (m_phase)
        PH_IDLE: begin
          if (pc_load) begin
            m_pc     = pc_load_value;
            m_bvalid = 1'b0;
          end else if (fetch) begin
            if (m_bvalid && (m_btag == m_pc[15:1])) begin
              m_give_byte = byte_at(m_pc);
              m_phase     = PH_GIVE;
            end else begin
              m_req_addr = m_pc[15:1];
              m_phase    = PH_WAIT;
            end
          end
        end
        PH_WAIT: begin
          if (pc_load) begin
            m_pc     = pc_load_value;
            m_bvalid = 1'b0;
            m_phase  = mem_ack ? PH_IDLE : PH_DISCARD;
          end else if (mem_ack) begin
            m_bvalid    = 1'b1;
            m_btag      = m_req_addr;
            m_give_byte = byte_at(m_pc);
            m_phase     = PH_GIVE;
          end
        end
        PH_GIVE: begin
          if (pc_load) begin
            m_pc     = pc_load_value;
            m_bvalid = 1'b0;
          end else begin
            m_pc = 16'((32'(m_pc) + 1) % 65536);
          end
          m_phase = PH_IDLE;
        end
        default: begin
          if (pc_load) begin
            m_pc     = pc_load_value;
            m_bvalid = 1'b0;
          end
          if (mem_ack) m_phase = PH_IDLE;
        end
      endcase
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("cmp_byte_valid", {31'h0, byte_valid}, {31'h0, m_phase == PH_GIVE});
      checkOutput("cmp_busy", {31'h0, busy}, {31'h0, m_phase != PH_IDLE});
      checkOutput("cmp_mem_req", {31'h0, mem_req},
                  {31'h0, (m_phase == PH_WAIT) || (m_phase == PH_DISCARD)});
      if ((m_phase == PH_WAIT) || (m_phase == PH_DISCARD)) begin
        checkOutput("cmp_mem_addr", {17'h0, mem_addr}, {17'h0, m_req_addr});
      end
      if (m_phase == PH_GIVE) begin
        checkOutput("cmp_byte_out", {24'h0, byte_out}, {24'h0, m_give_byte});
      end
      checkOutput("cmp_pc", {16'h0, pc}, {16'h0, m_pc});
      checkOutput("cmp_param_even", {31'h0, param_even}, {31'h0, ~m_pc[0]});
      checkOutput("cmp_operand", operand, m_operand);
    end
  end

  // Global time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    logic [7:0] b;
    int         pulses;
    logic       saw_valid;
    logic       dropped;

    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[15'h0000] = 16'hB601;
    mem[15'h0010] = 16'h1234;
    mem[15'h0011] = 16'h5678;
    mem[15'h0012] = 16'h9A00;
    mem[15'h0020] = 16'h5511;
    mem[15'h0081] = 16'hCAFE;
    mem[15'h0082] = 16'hBEEF;
    mem[15'h7FFF] = 16'hA55A;

    // Reset values.
    repeat (3) @(negedge clk);
    checkOutput("rst_byte_valid", {31'h0, byte_valid}, 32'h0);
    checkOutput("rst_mem_req", {31'h0, mem_req}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_param_even", {31'h0, param_even}, 32'h1);
    checkOutput("rst_pc", {16'h0, pc}, 32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Miss then hit on halfword 0.
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    checkOutput("t1_req", {31'h0, mem_req}, 32'h1);
    checkOutput("t1_addr", {17'h0, mem_addr}, 32'h0);
    wait_byte("t1_first", b);
    checkOutput("t1_first_byte", {24'h0, b}, 32'hB6);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    checkOutput("t1_hit_no_req", {31'h0, mem_req}, 32'h0);
    checkOutput("t1_hit_valid", {31'h0, byte_valid}, 32'h1);
    checkOutput("t1_hit_byte", {24'h0, byte_out}, 32'h01);
    @(negedge clk);
    checkOutput("t1_pc", {16'h0, pc}, 32'h2);
    checkOutput("t1_param_even", {31'h0, param_even}, 32'h1);
    checkOutput("t1_model_pc", {16'h0, m_pc}, 32'h2);

    // Operand assembly.
    applyStimulus(1'b0, 1'b1, 16'h0020, 1'b0);
    fetch_one("t2_b0", 1'b1, b);
    checkOutput("t2_b0_val", {24'h0, b}, 32'h12);
    fetch_one("t2_b1", 1'b0, b);
    fetch_one("t2_b2", 1'b0, b);
    fetch_one("t2_b3", 1'b0, b);
    checkOutput("t2_b3_val", {24'h0, b}, 32'h78);
    checkOutput("t2_operand", operand, 32'h12345678);
    checkOutput("t2_model_operand", m_operand, 32'h12345678);
    fetch_one("t2_b4", 1'b1, b);
    checkOutput("t2_b4_val", {24'h0, b}, 32'h9A);
    checkOutput("t2_operand_clr", operand, 32'h0000009A);

    // Odd-target load.
    applyStimulus(1'b0, 1'b1, 16'h0103, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    checkOutput("t3_addr", {17'h0, mem_addr}, 32'h081);
    wait_byte("t3_byte", b);
    checkOutput("t3_byte_val", {24'h0, b}, 32'hFE);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    checkOutput("t3_pc", {16'h0, pc}, 32'h0104);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    checkOutput("t3_next_req", {31'h0, mem_req}, 32'h1);
    checkOutput("t3_next_addr", {17'h0, mem_addr}, 32'h082);
    wait_byte("t3_next", b);
    checkOutput("t3_next_val", {24'h0, b}, 32'hBE);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);

    // Abort mid-request with a slow memory.
    fixed_delay = 3;
    applyStimulus(1'b0, 1'b1, 16'h0300, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0040, 1'b0);
    fixed_delay = 0;
    checkOutput("t4_req_held", {31'h0, mem_req}, 32'h1);
    checkOutput("t4_addr_held", {17'h0, mem_addr}, 32'h180);
    saw_valid = 1'b0;
    dropped   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (byte_valid === 1'b1) saw_valid = 1'b1;
      if (mem_req === 1'b0) begin
        dropped = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("t4_req_dropped", {31'h0, dropped}, 32'h1);
    checkOutput("t4_no_byte", {31'h0, saw_valid}, 32'h0);
    checkOutput("t4_idle", {31'h0, busy}, 32'h0);
    checkOutput("t4_pc", {16'h0, pc}, 32'h0040);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    checkOutput("t4_new_addr", {17'h0, mem_addr}, 32'h020);
    wait_byte("t4_byte", b);
    checkOutput("t4_byte_val", {24'h0, b}, 32'h55);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);

    // PC wrap.
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    checkOutput("t5_addr", {17'h0, mem_addr}, 32'h7FFF);
    wait_byte("t5_byte", b);
    checkOutput("t5_byte_val", {24'h0, b}, 32'h5A);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    checkOutput("t5_pc", {16'h0, pc}, 32'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    checkOutput("t5_miss_req", {31'h0, mem_req}, 32'h1);
    checkOutput("t5_miss_addr", {17'h0, mem_addr}, 32'h0);
    wait_byte("t5_next", b);
    checkOutput("t5_next_val", {24'h0, b}, 32'hB6);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);

    // Fetches while busy are ignored.
    fixed_delay = 2;
    applyStimulus(1'b0, 1'b1, 16'h0200, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (byte_valid === 1'b1) pulses++;
      fetch = busy;
      @(negedge clk);
    end
    fetch = 1'b0;
    checkOutput("t6_one_pulse", pulses, 32'h1);
    checkOutput("t6_pc", {16'h0, pc}, 32'h0201);

    // Asynchronous reset in the middle of a request.
    fixed_delay = 3;
    applyStimulus(1'b0, 1'b1, 16'h0400, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    checkOutput("t7_in_req", {31'h0, mem_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t7_mem_req", {31'h0, mem_req}, 32'h0);
    checkOutput("t7_mem_addr", {17'h0, mem_addr}, 32'h0);
    checkOutput("t7_byte_valid", {31'h0, byte_valid}, 32'h0);
    checkOutput("t7_byte_out", {24'h0, byte_out}, 32'h0);
    checkOutput("t7_operand", operand, 32'h0);
    checkOutput("t7_pc", {16'h0, pc}, 32'h0);
    checkOutput("t7_busy", {31'h0, busy}, 32'h0);
    checkOutput("t7_param_even", {31'h0, param_even}, 32'h1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic with random memory latency.
    random_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      fetch       = ($urandom_range(0, 9) < 4);
      operand_clr = ($urandom_range(0, 9) == 0);
      pc_load     = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0, 1:    pc_load_value = 16'($urandom_range(0, 31));
        2:       pc_load_value = 16'hFFF0 | 16'($urandom_range(0, 15));
        default: pc_load_value = 16'($urandom);
      endcase
      @(negedge clk);
    end
    fetch       = 1'b0;
    operand_clr = 1'b0;
    pc_load     = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("rnd_settled", {31'h0, busy}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/bytecode_byte_fetch.md
# bytecode_byte_fetch

Bytecode byte supplier sitting directly downstream of `fetch_byte`. It turns the single-cycle `fetch` strobe into one delivered bytecode byte per request, and owns the JVM program counter. It also keeps a one-halfword line buffer in front of the 16-bit bytecode memory and shift-accumulates multi-byte operands for the decode state machine. It also drives `param_even` back to `fetch_byte`.

## Interface
- `ADDR_W`, 16, byte-address width of the JVM PC (bytecode memory is `ADDR_W-1` halfword-addressed)
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `fetch` in 1: request next byte (from `fetch_byte`); sampled only when `busy`=0
- `pc_load` in 1: load new PC (branch/invoke target)
- `pc_load_value` in ADDR_W: target byte address
- `operand_clr` in 1: clear operand accumulator
- `mem_req` out 1: bytecode memory read request
- `mem_addr` out ADDR_W-1: halfword address
- `mem_ack` in 1: read data valid this cycle
- `mem_rdata` in 16: halfword, big-endian (even byte = [15:8])
- `byte_valid` out 1: one-cycle pulse, `byte_out` valid
- `byte_out` out 8: delivered bytecode byte
- `operand` out 32: shift accumulator of delivered bytes
- `pc` out ADDR_W: address of next byte to deliver
- `param_even` out 1: `~pc[0]`
- `busy` out 1: high in every state except IDLE

## Operation
- Line buffer: 16-bit `buf_data`, tag `buf_addr` (ADDR_W-1), `buf_valid`.
- States:
  - IDLE: on `fetch`, hit (`buf_valid && buf_addr==pc[ADDR_W-1:1]`) -> DELIVER; miss -> REQ.
  - REQ: `mem_req`=1, `mem_addr`=`pc[ADDR_W-1:1]`, held stable until `mem_ack`. On ack: buffer filled, tag set -> DELIVER.
  - DELIVER: `byte_valid`=1, `byte_out` = `buf_data[15:8]` if `pc[0]`=0 else `[7:0]`. `pc` <= `pc`+1. Return to IDLE.
  - DRAIN: entered when `pc_load` arrives in REQ. `mem_req` stays high until ack, data discarded, buffer stays invalid -> IDLE.
- `pc_load`:
  - In IDLE or DELIVER: `pc` <= `pc_load_value`, `buf_valid` <= 0. In DELIVER the byte is still delivered, but the increment is overridden by the load.
  - In REQ: PC loaded, go to DRAIN. In DRAIN: PC reloaded, stay in DRAIN.
  - A `fetch` coincident with `pc_load` in IDLE is dropped.
- `fetch` while `busy`=1 is ignored (no queueing); upstream guarantees spacing.
- Operand:
  - On `byte_valid`: `operand` <= `{operand[23:0], byte_out}`.
  - `operand_clr` alone: `operand` <= 0.
  - `operand_clr` with `byte_valid`: `operand` <= `{24'b0, byte_out}`.
- PC wraps modulo 2^ADDR_W. Tag compare uses the wrapped value.
- Reset (async, all outputs):
  - State IDLE, `pc`=0, `buf_valid`=0, `buf_data`=0, `buf_addr`=0.
  - Outputs: `byte_valid`=0, `byte_out`=0, `operand`=0, `mem_req`=0, `mem_addr`=0, `busy`=0, `param_even`=1.
  - Reset mid-REQ drops `mem_req` immediately. Memory must tolerate an abandoned request.

## Timing
- Hit: `fetch` sampled at edge N -> `byte_valid` high in cycle N+1 -> `pc`/`param_even` updated at edge N+2. One byte per 2 cycles sustained.
- Miss: `fetch` at edge N -> `mem_req` high from cycle N+1. Ack sampled at edge M -> `byte_valid` in cycle M+1. Zero-wait memory (ack in first REQ cycle) gives a 3-cycle miss.
- Outputs are registered except `param_even` (decoded from registered `pc`) and `busy` (decoded from state register).
- Second byte of a halfword is always a hit unless `pc_load` intervened.

## Test plan
- Reset, memory word 0 = 0xB6_01. Two fetches spaced 2 cycles apart:
  - First fetch misses: `mem_req` for addr 0, then `byte_out`=0xB6.
  - Second fetch hits: no `mem_req`, `byte_out`=0x01.
  - `pc`=2, `param_even`=1.
- Operand assembly:
  - `operand_clr` with the first byte, then bytes 0x12,0x34,0x56,0x78 -> `operand`=0x12345678.
  - `operand_clr` coincident with byte 0x9A -> `operand`=0x0000009A.
- Odd-target load:
  - `pc_load` 0x0103 in IDLE, then `fetch` -> `mem_addr`=0x081, `byte_out`=low byte of that word, `pc`=0x0104.
  - Next fetch misses on 0x082.
- Abort mid-request:
  - `pc_load` 0x0040 during REQ with ack delayed 3 cycles -> `mem_req` held until ack, no `byte_valid`, state returns to IDLE.
  - Next fetch requests 0x020.
- Wrap: `pc_load` 0xFFFF, fetch -> byte from odd half of word 0x7FFF, `pc`=0x0000; next fetch misses on addr 0.
- Assert `rst_n` low mid-REQ -> all outputs at reset values asynchronously. `fetch` during `busy` is ignored: `byte_valid` pulses exactly once per accepted fetch.
